// File: rtl/mdu_pkg.sv
// Multiply/divide unit command encoding and iteration count.
package MDUType;
   typedef enum logic [2:0] {
      NONE  = 3'd0,
      MULT  = 3'd1,
      MULTU = 3'd2,
      DIV   = 3'd3,
      DIVU  = 3'd4,
      MTHI  = 3'd5,
      MTLO  = 3'd6
   } mdu_cmd_t;

   localparam int MDU_ITER = 32;
endpackage

// File: rtl/types_pkg.sv
// Shared datapath types used across the core.
package Types;
   typedef logic [31:0] op_t;
endpackage

// File: rtl/mdu_abs.sv
// Operand magnitude and sign extraction; unsigned commands pass the value through.
module mdu_abs
   import Types::*;
(
   input  op_t  val,
   input  logic is_signed,
   output op_t  mag,
   output logic neg
);
   always_comb begin
      neg = is_signed & val[31];
      mag = neg ? (~val + 32'd1) : val;
   end
endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO registers: one shift-add or
// restoring-subtract step per cycle on magnitudes, sign fixed on the last step.
module mdu
   import Types::*;
   import MDUType::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     start,
   input  mdu_cmd_t cmd,
   input  op_t      a,
   input  op_t      b,
   output logic     busy,
   output logic     done,
   output logic     div_by_zero,
   output op_t      hi,
   output op_t      lo
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0] state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   mdu_cmd_t   cmd_q, cmd_d;
   op_t        a_q, a_d, mag_a_q, mag_a_d, mag_b_q, mag_b_d;
   logic       neg_a_q, neg_a_d, neg_b_q, neg_b_d, bz_q, bz_d;
   op_t        rem_q, rem_d, quo_q, quo_d;
   op_t        hi_q, hi_d, lo_q, lo_d;
   logic       dbz_q, dbz_d;

   logic        is_signed, is_iter, is_div;
   op_t         mag_a, mag_b;
   logic        neg_a, neg_b;
   logic [32:0] add_sum, shifted;
   op_t         step_rem, step_quo, quo_fix, rem_fix;
   logic [63:0] prod_fix;

   mdu_abs u_abs_a (.val(a), .is_signed(is_signed), .mag(mag_a), .neg(neg_a));
   mdu_abs u_abs_b (.val(b), .is_signed(is_signed), .mag(mag_b), .neg(neg_b));

   always_comb begin
      is_signed = (cmd == MULT) || (cmd == DIV);
      is_iter   = cmd inside {MULT, MULTU, DIV, DIVU};
      is_div    = (cmd_q == DIV) || (cmd_q == DIVU);

      // Multiply: {rem,quo} shifts right with the multiplier in quo.
      // Divide: dividend shifts out of quo into rem, quotient bits shift in.
      add_sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, mag_a_q} : 33'd0);
      shifted = {rem_q, quo_q[31]};
      if (is_div) begin
         if (shifted >= {1'b0, mag_b_q}) begin
            step_rem = 32'(shifted - {1'b0, mag_b_q});
            step_quo = {quo_q[30:0], 1'b1};
         end else begin
            step_rem = shifted[31:0];
            step_quo = {quo_q[30:0], 1'b0};
         end
      end else begin
         step_rem = add_sum[32:1];
         step_quo = {add_sum[0], quo_q[31:1]};
      end

      prod_fix = (neg_a_q ^ neg_b_q) ? -{step_rem, step_quo} : {step_rem, step_quo};
      quo_fix  = (neg_a_q ^ neg_b_q) ? -step_quo : step_quo;
      rem_fix  = neg_a_q ? -step_rem : step_rem;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      a_d     = a_q;
      mag_a_d = mag_a_q;
      mag_b_d = mag_b_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      bz_d    = bz_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && is_iter) begin
               state_d = S_RUN;
               cnt_d   = '0;
               cmd_d   = cmd;
               a_d     = a;
               mag_a_d = mag_a;
               mag_b_d = mag_b;
               neg_a_d = neg_a;
               neg_b_d = neg_b;
               bz_d    = (b == '0);
               rem_d   = '0;
               quo_d   = ((cmd == DIV) || (cmd == DIVU)) ? mag_a : mag_b;
            end else if (start && (cmd == MTHI)) begin
               hi_d = a;
            end else if (start && (cmd == MTLO)) begin
               lo_d = a;
            end
         end
         S_RUN: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(MDU_ITER - 1)) begin
               state_d = S_DONE;
               if (!is_div) begin
                  {hi_d, lo_d} = prod_fix;
               end else if (bz_q) begin
                  hi_d  = a_q;
                  lo_d  = '1;
                  dbz_d = 1'b1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         cmd_q   <= NONE;
         a_q     <= '0;
         mag_a_q <= '0;
         mag_b_q <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         bz_q    <= 1'b0;
         rem_q   <= '0;
         quo_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         a_q     <= a_d;
         mag_a_q <= mag_a_d;
         mag_b_q <= mag_b_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         bz_q    <= bz_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst_n: input, 1 bit, synchronous active-low reset sampled on the rising edge of clk.
REQ-004 Port start: input, 1 bit, requests a command; sampled only in IDLE.
REQ-005 Port cmd: input, mdu_cmd_t, command: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-006 Port a: input, op_t (32 bit), first operand: multiplicand, dividend, or MTHI/MTLO source.
REQ-007 Port b: input, op_t (32 bit), second operand: multiplier or divisor.
REQ-008 Port busy: output, 1 bit, high while an iterative operation is in RUN.
REQ-009 Port done: output, 1 bit, one-cycle pulse when hi/lo hold a new MULT/DIV result.
REQ-010 Port div_by_zero: output, 1 bit, high together with done when a DIV/DIVU had b == 0.
REQ-011 Port hi: output, op_t, HI register, consumed downstream by the ALU result mux (MFHI path).
REQ-012 Port lo: output, op_t, LO register, consumed downstream by the ALU result mux (MFLO path).

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 and cmd in {MULT, MULTU, DIV, DIVU}, the block SHALL latch a, b and cmd, clear the 6-bit iteration counter and go to RUN.
REQ-015 RUN SHALL perform one shift-add (multiply) or restoring-subtract (divide) step per cycle on operand magnitudes; after the 32nd step it SHALL apply sign correction, write hi/lo and go to DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-017 Latency: with start accepted at the edge ending cycle 0, busy SHALL be 1 in cycles 1..32, and done=1 with the valid result on hi/lo in cycle 33.
REQ-018 MULT SHALL give {hi,lo} = exact signed 64-bit product; MULTU SHALL give the unsigned 64-bit product.
REQ-019 DIV SHALL give lo = quotient truncated toward zero and hi = remainder carrying the sign of the dividend; DIVU SHALL give the unsigned quotient and remainder.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, with no flag.
REQ-021 DIV/DIVU with b=0 SHALL still take 32 steps, then give lo=0xFFFFFFFF and hi=a, and assert div_by_zero=1 for the DONE cycle only.
REQ-022 In IDLE with start=1, MTHI SHALL load hi<=a and MTLO SHALL load lo<=a at that edge; busy and done SHALL stay 0.
REQ-023 start with cmd=NONE, and any start in RUN or DONE, SHALL be ignored without side effects.
REQ-024 Changes on a, b and cmd during RUN or DONE SHALL NOT affect the result in progress.
REQ-025 hi and lo SHALL hold their values except on the DONE-entry write, an MTHI/MTLO write, or reset.

Reset
REQ-026 With rst_n=0 at a rising edge, the block SHALL go to IDLE, clear hi, lo and the counter to 0, and drive busy, done and div_by_zero to 0 from the next cycle.
REQ-027 A reset during RUN SHALL abort the operation with no partial write to hi/lo and no done pulse.

Structure
REQ-028 mdu_cmd_t and the constant MDU_ITER=32 SHALL be defined in a shared package MDUType; op_t SHALL come from Types.
REQ-029 Magnitude and sign extraction of an operand SHALL live in sub-module mdu_abs, instantiated once per operand; everything else stays in mdu.

Verification
REQ-030 MULT a=0xFFFFFFFD, b=0x00000007 -> done in cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-031 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 32 cycles.
REQ-032 DIV a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-033 DIV a=5, b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 with done; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 Second start in cycle 5 is ignored (single done in cycle 33); rst_n=0 at cycle 10 -> busy=0, hi=lo=0 next cycle, no done; MTHI a=0x1234 in IDLE -> hi=0x1234 next cycle, busy stays 0.
